instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch and sequencing unit that drives the instruction ROM.
- Holds the program counter (PC) and presents it on iptr. The ROM returns the 20-bit instruction combinationally in the same cycle.
- Resolves relative branches against the compare flags and stops on the `done` opcode.
- Issues registered instructions to decode/execute, one per cycle, with a stall handshake.

Parameters:
- PW, 9, PC / iptr width
- IW, 20, instruction width
- CW, 16, width of the retired-instruction counter

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run at start_addr (honoured only in IDLE or HALT)
- start_addr  in  PW  entry point, e.g. 0x001 product, 0x019 string match, 0x02A closest pair
- iptr  out  PW  current PC to the instruction ROM
- inst  in  IW  ROM data for iptr, valid in the same cycle
- stall  in  1  execute not ready; freeze the PC and hold the issued instruction
- flag_we  in  1  execute is writing compare flags this cycle
- flag_eq, flag_lt, flag_gt  in  1 each  compare results accompanying flag_we
- inst_out  out  IW  issued instruction (registered)
- inst_pc  out  PW  address of inst_out
- inst_valid  out  1  inst_out is a new instruction this cycle
- busy  out  1  high in RUN
- done  out  1  high in HALT
- retired  out  CW  count of instructions issued since the last start

Behaviour:
Reset (asynchronous, any state):
- state = IDLE, PC = 0.
- inst_out = 0, inst_pc = 0, inst_valid = 0.
- Internal flags EQ/LT/GT = 0.
- retired = 0, busy = 0, done = 0.

States:
- IDLE: iptr = PC. No issue. On start: PC ← start_addr, flags cleared, retired ← 0, go to RUN.
- RUN, each cycle with stall = 0:
  - Register inst_out ← inst, inst_pc ← PC, inst_valid ← 1, retired ← retired + 1 (saturating at 2^CW − 1).
  - Update the PC from the opcode in inst[19:15]:
    - 00111 be: taken if EQ
    - 01000 bl: taken if LT
    - 01001 bg: taken if GT
    - 01010 ba: always taken
    - Taken: PC ← PC + sext(inst[14:0]), truncated to PW bits (mod 512; wrap allowed). Not taken: PC ← PC + 1.
    - 01110 done: PC unchanged, go to HALT. The done instruction itself is issued.
    - All other opcodes: PC ← PC + 1. PC 0x1FF + 1 wraps to 0x000.
- RUN with stall = 1:
  - PC, inst_out, inst_pc and retired hold; inst_valid ← 0.
  - The flag bypass still applies.
- HALT: done = 1, inst_valid = 0. A start pulse behaves as in IDLE (restart).

Flags and bypass:
- Internal EQ/LT/GT load from flag_eq/lt/gt whenever flag_we = 1.
- The branch decision uses the bypassed value: flag_* if flag_we else the registers.
- This lets a compare issued in cycle t steer the branch fetched in cycle t+1 with zero bubbles.

Branch timing:
- Branches cost no extra cycles; the redirect is visible on iptr the next cycle.
- Offset is relative to the branch's own address.

Other rules:
- start during RUN is ignored.
- flag_we in IDLE/HALT still updates the flags (harmless; cleared on start).
- Reset mid-run aborts immediately with no further issue.

Decomposition:
- isa_pkg:
  - opcode constants OP_ADD=00000 … OP_BE=00111, OP_BL=01000, OP_BG=01001, OP_BA=01010, OP_LD=01100, OP_ST=01101, OP_DONE=01110
  - state enum {IDLE, RUN, HALT}
  - field slice constants OPC_HI=19, OPC_LO=15, OFF_W=15
- Sub-module branch_resolve (combinational): inputs opcode, offset, PC, bypassed flags; outputs next_pc and is_done. Shared with any future fetch variant.

Test Plan:
- Reset, then start with start_addr=0x001 against a ROM stub where 0x010 = bl −13 and flag_we=1, lt=1 in the cycle the cmp at 0x00F issues -> iptr sequence 0x00F, 0x010, 0x003; inst_pc follows one cycle later.
- Same branch with flag_we=0 and stored LT=0 -> 0x010 then 0x011; be at 0x005 offset +4 with EQ=1 -> 0x009.
- start_addr=0x000 with ROM[0] = done -> one issue (inst_out=0x70000, inst_valid pulse), done=1, busy=0, retired=1; a second start restarts the run and retired returns to 1.
- Hold stall=1 for 3 cycles mid-run -> iptr, inst_out and retired frozen, inst_valid=0; release resumes with no lost or duplicated instruction.
- ba with offset 0x7FFF (−1) at PC 0x000 -> PC wraps to 0x1FF; straight-line execution at 0x1FF -> next PC 0x000.
- Assert Reset_n low asynchronously mid-run, between clock edges -> all outputs 0 immediately, state IDLE, start pulses ignored until Reset_n is released.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA constants shared by the fetch path: opcode encodings, instruction field
// positions and the sequencer state type.
package isa_pkg;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 15;
  localparam int OFF_W  = 15;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_BE   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_BL   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_BG   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_BA   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b01101;
  localparam logic [OPC_W-1:0] OP_DONE = 5'b01110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve.sv
// Next-PC selection for one fetched instruction: relative branches against
// the supplied flags, hold on done, otherwise sequential (all modulo 2^PW).
module branch_resolve
  import isa_pkg::*;
#(
  parameter int PW = 9
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [OFF_W-1:0] offset,
  input  logic [PW-1:0]    pc,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  output logic [PW-1:0]    next_pc,
  output logic             is_done
);

  // Sign-extend first so the truncation below is correct for any PW.
  logic [PW+OFF_W-1:0] off_ext;
  logic                taken;

  assign off_ext = {{PW{offset[OFF_W-1]}}, offset};

  always_comb begin
    taken   = 1'b0;
    is_done = 1'b0;
    case (opcode)
      OP_BE:   taken = eq;
      OP_BL:   taken = lt;
      OP_BG:   taken = gt;
      OP_BA:   taken = 1'b1;
      OP_DONE: is_done = 1'b1;
      default: taken = 1'b0;
    endcase

    if (is_done) begin
      next_pc = pc;
    end else if (taken) begin
      next_pc = pc + off_ext[PW-1:0];
    end else begin
      next_pc = pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing unit: owns the PC, issues one registered instruction per
// non-stalled RUN cycle and halts on the done opcode.
module instr_fetch
  import isa_pkg::*;
#(
  parameter int PW = 9,
  parameter int IW = 20,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [PW-1:0] start_addr,
  output logic [PW-1:0] iptr,
  input  logic [IW-1:0] inst,
  input  logic          stall,
  input  logic          flag_we,
  input  logic          flag_eq,
  input  logic          flag_lt,
  input  logic          flag_gt,
  output logic [IW-1:0] inst_out,
  output logic [PW-1:0] inst_pc,
  output logic          inst_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] retired
);

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [IW-1:0] inst_out_q, inst_out_d;
  logic [PW-1:0] inst_pc_q, inst_pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic          eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [CW-1:0] retired_q, retired_d;

  // A compare landing this cycle steers the branch fetched this cycle.
  logic          eq_byp, lt_byp, gt_byp;
  logic [PW-1:0] next_pc;
  logic          is_done;

  assign eq_byp = flag_we ? flag_eq : eq_q;
  assign lt_byp = flag_we ? flag_lt : lt_q;
  assign gt_byp = flag_we ? flag_gt : gt_q;

  branch_resolve #(.PW(PW)) u_branch (
    .opcode  (inst[OPC_HI:OPC_LO]),
    .offset  (inst[OFF_W-1:0]),
    .pc      (pc_q),
    .eq      (eq_byp),
    .lt      (lt_byp),
    .gt      (gt_byp),
    .next_pc (next_pc),
    .is_done (is_done)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = 1'b0;
    eq_d         = flag_we ? flag_eq : eq_q;
    lt_d         = flag_we ? flag_lt : lt_q;
    gt_d         = flag_we ? flag_gt : gt_q;
    retired_d    = retired_q;

    case (state_q)
      RUN: begin
        if (!stall) begin
          inst_out_d   = inst;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = next_pc;
          if (retired_q != {CW{1'b1}}) begin
            retired_d = retired_q + 1'b1;
          end
          if (is_done) begin
            state_d = HALT;
          end
        end
      end
      default: begin
        // IDLE and HALT both accept a (re)start; start in RUN is ignored.
        if (start) begin
          state_d   = RUN;
          pc_d      = start_addr;
          eq_d      = 1'b0;
          lt_d      = 1'b0;
          gt_d      = 1'b0;
          retired_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
      gt_q         <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
      retired_q    <= retired_d;
    end
  end

  assign iptr       = pc_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == HALT);
  assign retired    = retired_q;

endmodule
